// File: rtl/round_ctrl.sv
// round_ctrl: game-round sequencer. One question per OK rising edge:
// countdown, answer window, judging, result display, and after the last
// question a final WIN/LOSE/TIE display that clears the match scores.
module round_ctrl #(
   parameter int TICK_DIV    = 50_000_000,
   parameter int COUNTDOWN_S = 3,
   parameter int ANSWER_S    = 9,
   parameter int RESULT_S    = 2,
   parameter int QUESTIONS   = 5
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       OK,
   input  logic [3:0] NUM,
   input  logic       ANS_1P,
   input  logic       HIT_1P,
   input  logic       ANS_2P,
   input  logic       HIT_2P,
   output logic [3:0] STATE,
   output logic [3:0] PROB,
   output logic [3:0] SEC,
   output logic [3:0] SCORE_1P,
   output logic [3:0] SCORE_2P,
   output logic [3:0] Q_NO
);

   localparam int              CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [3:0]      SEC_COUNT = 4'(COUNTDOWN_S);
   localparam logic [3:0]      SEC_PLAY  = 4'(ANSWER_S);
   localparam logic [3:0]      SEC_RES   = 4'(RESULT_S);
   localparam logic [3:0]      Q_LAST    = 4'(QUESTIONS);

   // Codes are what the ready block decodes, so they are fixed values.
   typedef enum logic [3:0] {
      IDLE  = 4'b0000,
      COUNT = 4'b0001,
      PLAY  = 4'b0010,
      DRAW  = 4'b0110,
      TIE   = 4'b0111,
      GOOD  = 4'b1000,
      OUCH  = 4'b1001,
      WIN   = 4'b1010,
      LOSE  = 4'b1011
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] pre_q, pre_d;
   logic          ok_d;
   logic [3:0]    sec_q, sec_d;
   logic [3:0]    prob_q, prob_d;
   logic [3:0]    s1_q, s1_d;
   logic [3:0]    s2_q, s2_d;
   logic [3:0]    qno_q, qno_d;

   logic start, tick, expire, load, give_1p, give_2p, num_ok;

   assign start  = OK & ~ok_d;
   assign tick   = (pre_q == TICK_LAST);
   assign expire = tick && (sec_q == 4'd1);
   assign num_ok = (NUM != 4'd0) && (NUM <= 4'd10);

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'd15) ? v : v + 4'd1;
   endfunction

   // State register and all timed/display registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         pre_q   <= '0;
         ok_d    <= 1'b0;
         sec_q   <= '0;
         prob_q  <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         qno_q   <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q <= state_d;
         pre_q   <= pre_d;
         ok_d    <= OK;
         sec_q   <= sec_d;
         prob_q  <= prob_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         qno_q   <= qno_d;
      end
   end

   // Next-state, timer reload, judging and score bookkeeping.
   always_comb begin
      // NOTE: every output defaults here first so no path infers a latch.
      state_d = state_q;
      sec_d   = sec_q;
      prob_d  = prob_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      qno_d   = qno_q;
      load    = 1'b0;
      give_1p = 1'b0;
      give_2p = 1'b0;

      if (tick && (sec_q != 4'd0)) sec_d = sec_q - 4'd1;

      unique case (state_q)
         IDLE: begin
            if (start && num_ok) begin
               prob_d  = NUM;
               sec_d   = SEC_COUNT;
               load    = 1'b1;
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (expire) begin
               sec_d   = SEC_PLAY;
               load    = 1'b1;
               state_d = PLAY;
            end
         end
         PLAY: begin
            // An answer in the expiry cycle still counts as an answer.
            if (ANS_1P && ANS_2P) begin
               give_1p = HIT_1P && !HIT_2P;
               give_2p = HIT_2P && !HIT_1P;
            end else if (ANS_1P) begin
               give_1p = HIT_1P;
               give_2p = !HIT_1P;
            end else if (ANS_2P) begin
               give_2p = HIT_2P;
               give_1p = !HIT_2P;
            end
            if (ANS_1P || ANS_2P || expire) begin
               sec_d   = SEC_RES;
               load    = 1'b1;
               qno_d   = (qno_q == Q_LAST) ? qno_q : qno_q + 4'd1;
               if (give_1p) begin
                  s1_d    = sat_inc(s1_q);
                  state_d = GOOD;
               end else if (give_2p) begin
                  s2_d    = sat_inc(s2_q);
                  state_d = OUCH;
               end else begin
                  state_d = DRAW;
               end
            end
         end
         DRAW, GOOD, OUCH: begin
            if (expire) begin
               if (qno_q == Q_LAST) begin
                  sec_d   = SEC_RES;
                  load    = 1'b1;
                  if (s1_q > s2_q)      state_d = WIN;
                  else if (s1_q < s2_q) state_d = LOSE;
                  else                  state_d = TIE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         WIN, LOSE, TIE: begin
            if (expire) begin
               state_d = IDLE;
               s1_d    = '0;
               s2_d    = '0;
               qno_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Restarting the prescaler on every load makes each first second full.
      pre_d = (load || tick) ? '0 : pre_q + CW'(1);
   end

   assign STATE    = state_q;
   assign PROB     = prob_q;
   assign SEC      = sec_q;
   assign SCORE_1P = s1_q;
   assign SCORE_2P = s2_q;
   assign Q_NO     = qno_q;

endmodule

// File: doc/round_ctrl.md
Name: round_ctrl

Overview:
- Game-round sequencer that consumes the start handshake (OK, NUM) issued by the two-player ready block.
- Runs one question per OK rising edge: countdown, answer window, judging, then result display.
- Drives the 4-bit STATE bus back to the ready block. Result codes 0110/1000/1001/1010/1011 clear both players' ready latches.
- Also drives problem index, seconds display and scores to the display/board logic.

Parameters:
- TICK_DIV, 50_000_000: CLK cycles per 1 s tick.
- COUNTDOWN_S, 3: seconds in COUNT before the answer window opens.
- ANSWER_S, 9: seconds allowed to answer.
- RESULT_S, 2: seconds each result state is held.
- QUESTIONS, 5: questions per match (1..15).

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- OK  in  1  start level from ready block; start = 0->1 edge
- NUM  in  4  problem index from ready block, valid 1..10 while OK high
- ANS_1P  in  1  1P answer-submit pulse (1 cycle)
- HIT_1P  in  1  1P answer correct; qualified by ANS_1P
- ANS_2P  in  1  2P answer-submit pulse (1 cycle)
- HIT_2P  in  1  2P answer correct; qualified by ANS_2P
- STATE  out  4  current state code
- PROB  out  4  latched problem index
- SEC  out  4  seconds remaining in the current timed state
- SCORE_1P  out  4  1P points
- SCORE_2P  out  4  2P points
- Q_NO  out  4  questions completed

Behaviour:
- Reset (RST=0, async): all outputs 0, STATE=IDLE, prescaler 0, ok_d=0.
- ok_d is OK registered. Start = OK & ~ok_d. A held-high OK never restarts.
- Prescaler counts 0..TICK_DIV-1; tick when it equals TICK_DIV-1.
- Prescaler clears to 0 whenever SEC is loaded, so the first second is always full.
- On a tick, SEC decrements. A state's timer expires on the tick where SEC==1; SEC reads 0 in the following state only if that state is IDLE.
- States and codes:
  - IDLE 0000: on start with NUM in 1..10, set PROB<=NUM, SEC<=COUNTDOWN_S, go to COUNT next cycle. A start with NUM 0 or >10 is ignored: stay in IDLE, PROB unchanged.
  - COUNT 0001: on expiry, SEC<=ANSWER_S, go to PLAY. ANS inputs are ignored.
  - PLAY 0010, evaluated in priority order, same cycle:
    - both ANS pulses in the same cycle: if exactly one HIT, the hitter scores and the result is GOOD (1P hit) or OUCH (2P hit); otherwise DRAW with no score change.
    - ANS_1P only: HIT_1P gives SCORE_1P+1 and GOOD; miss gives SCORE_2P+1 and OUCH.
    - ANS_2P only: HIT_2P gives SCORE_2P+1 and OUCH; miss gives SCORE_1P+1 and GOOD.
    - expiry with no answer: DRAW.
    - any answer before expiry wins over expiry in the same cycle.
  - Result states DRAW 0110, GOOD 1000, OUCH 1001: on entry SEC<=RESULT_S and Q_NO+1.
    - On expiry: if Q_NO==QUESTIONS, go to final; else go to IDLE, keeping scores and PROB.
  - Final states, entered with SEC<=RESULT_S:
    - WIN 1010 if SCORE_1P>SCORE_2P.
    - LOSE 1011 if SCORE_1P<SCORE_2P.
    - TIE 0111 if equal.
    - On expiry: go to IDLE with SCORE_1P, SCORE_2P and Q_NO cleared to 0 in that transition.
- Scores saturate at 15; Q_NO never exceeds QUESTIONS.
- A start edge outside IDLE is ignored and not queued.
- ANS pulses outside PLAY are ignored.
- Reset mid-round aborts immediately to the reset values.
- STATE, SEC, PROB, SCORE_*, Q_NO are all registered; STATE changes the cycle after the causing event.

Test Plan (TICK_DIV=4, COUNTDOWN_S=3, ANSWER_S=9, RESULT_S=2, QUESTIONS=2):
- Reset, then OK rises with NUM=7 -> next cycle STATE=0001, PROB=7, SEC=3; STATE=0010, SEC=9 after 12 clocks.
- In PLAY: ANS_1P=1, HIT_1P=1 -> STATE=1000, SCORE_1P=1, Q_NO=1; after 8 clocks STATE=0000.
- In PLAY: ANS_1P and ANS_2P in the same cycle, both HIT=1 -> STATE=0110, scores unchanged; both HIT=0 -> also 0110.
- Second question: ANS_2P with HIT_2P=0 -> GOOD, SCORE_1P=2. After result -> WIN 1010; after 8 clocks IDLE with SCORE_1P=0 and Q_NO=0.
- OK rises with NUM=0 -> STATE stays 0000. OK held high through a full question -> no second start until OK falls and rises again.
- RST=0 asserted mid-PLAY -> all outputs 0 immediately, without waiting for a CLK edge; no timeout DRAW is produced afterwards.
